// File: rtl/fetch_request_buffer_if.sv
// Fetch front-end bus bundle: redirect, cache fetch request/response and decode handoff.
// slave is the fetch buffer side; master is the side driving the cache and decode stimulus.
interface fetch_request_buffer_if;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        sub_new_request;
  logic [31:0] sub_addr;
  logic        sub_ready;
  logic        sub_data_valid;
  logic [31:0] sub_data_out;
  logic        dec_valid;
  logic [31:0] dec_pc;
  logic [31:0] dec_instr;
  logic        dec_pop;
  logic        flush_pending;

  modport slave (
    input  redirect, redirect_pc, sub_ready, sub_data_valid, sub_data_out, dec_pop,
    output sub_new_request, sub_addr, dec_valid, dec_pc, dec_instr, flush_pending
  );

  modport master (
    output redirect, redirect_pc, sub_ready, sub_data_valid, sub_data_out, dec_pop,
    input  sub_new_request, sub_addr, dec_valid, dec_pc, dec_instr, flush_pending
  );
endinterface

// File: rtl/fetch_request_buffer.sv
// Sequential fetch address generator with in-order response pairing and a {pc, instr}
// buffer for decode; redirects drop stale cache responses without stalling the cache.
module fetch_request_buffer #(
  parameter int          DEPTH           = 4,
  parameter int          MAX_OUTSTANDING = 2,
  parameter logic [31:0] RESET_PC        = 32'h8000_0000
) (
  input logic                  clk,
  input logic                  rst,
  fetch_request_buffer_if.slave bus
);

  localparam int PW = $clog2(DEPTH);
  localparam int QW = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  localparam int OW = $clog2(MAX_OUTSTANDING + 1);
  localparam int SW = CW + 1;

  localparam logic [OW-1:0] MAX_O   = OW'(MAX_OUTSTANDING);
  localparam logic [SW-1:0] DEPTH_S = SW'(DEPTH);
  localparam logic [QW-1:0] Q_LAST  = QW'(MAX_OUTSTANDING - 1);

  logic [31:0]   pc_r;
  logic [OW-1:0] outstanding;
  logic [OW-1:0] discard_cnt;

  logic [31:0]   buf_pc    [DEPTH];
  logic [31:0]   buf_instr [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [CW-1:0] count;

  logic [31:0]   pcq [MAX_OUTSTANDING];
  logic [QW-1:0] pcq_wr;
  logic [QW-1:0] pcq_rd;

  logic          pop;
  logic          rsp;
  logic          keep;
  logic          issue;
  logic [SW-1:0] credit_used;

  function automatic logic [QW-1:0] q_inc(input logic [QW-1:0] p);
    return (p == Q_LAST) ? '0 : p + QW'(1);
  endfunction

  // A same-cycle pop frees its slot immediately, so issue can refill it without a bubble.
  assign pop         = bus.dec_pop & (count != '0) & ~bus.redirect;
  assign rsp         = bus.sub_data_valid;
  assign keep        = rsp & (discard_cnt == '0) & ~bus.redirect;
  assign credit_used = SW'(outstanding) + SW'(count) - SW'(pop);
  assign issue       = ~rst & bus.sub_ready & ~bus.redirect &
                       (outstanding < MAX_O) & (credit_used < DEPTH_S);

  assign bus.sub_new_request = issue;
  assign bus.sub_addr        = pc_r;
  assign bus.dec_valid       = (count != '0);
  assign bus.dec_pc          = buf_pc[rd_ptr];
  assign bus.dec_instr       = buf_instr[rd_ptr];
  assign bus.flush_pending   = (discard_cnt != '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_r        <= RESET_PC;
      outstanding <= '0;
      discard_cnt <= '0;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count       <= '0;
      pcq_wr      <= '0;
      pcq_rd      <= '0;
    end else if (bus.redirect) begin
      // Everything still owed by the cache becomes stale, minus a response landing now.
      pc_r        <= bus.redirect_pc & 32'hFFFF_FFFC;
      outstanding <= outstanding - OW'(rsp);
      discard_cnt <= outstanding - OW'(rsp);
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count       <= '0;
      pcq_wr      <= '0;
      pcq_rd      <= '0;
    end else begin
      if (issue) begin
        pc_r   <= pc_r + 32'd4;
        pcq_wr <= q_inc(pcq_wr);
      end
      if (keep) begin
        pcq_rd <= q_inc(pcq_rd);
        wr_ptr <= wr_ptr + PW'(1);
      end
      if (pop)
        rd_ptr <= rd_ptr + PW'(1);
      if (rsp && (discard_cnt != '0))
        discard_cnt <= discard_cnt - OW'(1);
      count       <= count + CW'(keep) - CW'(pop);
      outstanding <= outstanding + OW'(issue) - OW'(rsp);
    end
  end

  // Storage needs no reset; validity is carried entirely by the pointers and counts.
  always_ff @(posedge clk) begin
    if (issue)
      pcq[pcq_wr] <= pc_r;
    if (keep) begin
      buf_pc[wr_ptr]    <= pcq[pcq_rd];
      buf_instr[wr_ptr] <= bus.sub_data_out;
    end
  end

`ifndef SYNTHESIS
  a_rsp_without_request: assert property (@(posedge clk) disable iff (rst)
    !(bus.sub_data_valid && (outstanding == '0)));
  a_discard_le_outstanding: assert property (@(posedge clk) disable iff (rst)
    discard_cnt <= outstanding);
`endif

endmodule

// File: tb/tb_fetch_request_buffer.sv
// Randomized bench for fetch_request_buffer: a queue-based reference model predicts issues
// and decode pairs; a separate monitor compares DUT outputs against the scoreboard queues.
module tb_fetch_request_buffer;
  localparam int          DEPTH    = 4;
  localparam int          MAXO     = 2;
  localparam logic [31:0] RESET_PC = 32'h8000_0000;

  typedef struct { logic [31:0] pc; bit stale; } fl_t;
  typedef struct { logic [31:0] pc; logic [31:0] instr; } de_t;

  logic clk = 1'b0;
  logic rst = 1'b1;

  fetch_request_buffer_if bus();

  fetch_request_buffer #(
    .DEPTH(DEPTH), .MAX_OUTSTANDING(MAXO), .RESET_PC(RESET_PC)
  ) dut (
    .clk(clk), .rst(rst), .bus(bus)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  int n_req    = 0;

  fl_t         inflight[$];
  de_t         exp_dec[$];
  logic [31:0] exp_addr[$];
  logic [31:0] m_pc = RESET_PC;

  int          pr_ready, pr_rsp, pr_pop, pr_redir;
  bit          force_redir = 1'b0;
  logic [31:0] force_pc    = '0;
  bit          mon_ei;
  int          n0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit any_stale();
    foreach (inflight[i]) if (inflight[i].stale) return 1'b1;
    return 1'b0;
  endfunction

  task automatic set_pr(input int r, input int s, input int p, input int d);
    pr_ready = r; pr_rsp = s; pr_pop = p; pr_redir = d;
  endtask

  // One cycle: drive inputs at negedge, predict issue, then advance the model at posedge.
  task automatic step();
    bit          rsp, iss, pop_eff, redir;
    logic [31:0] rdata, rpc;
    fl_t         fr;
    @(negedge clk);
    redir       = force_redir || ($urandom_range(99, 0) < pr_redir);
    rpc         = force_redir ? force_pc : $urandom;
    force_redir = 1'b0;
    rsp         = (inflight.size() > 0) && ($urandom_range(99, 0) < pr_rsp);
    rdata       = $urandom;
    bus.redirect       = redir;
    bus.redirect_pc    = rpc;
    bus.sub_ready      = ($urandom_range(99, 0) < pr_ready);
    bus.dec_pop        = ($urandom_range(99, 0) < pr_pop);
    bus.sub_data_valid = rsp;
    bus.sub_data_out   = rdata;
    pop_eff = bus.dec_pop && !redir && (exp_dec.size() > 0);
    iss = bus.sub_ready && !redir && (inflight.size() < MAXO) &&
          ((inflight.size() + exp_dec.size() - int'(pop_eff)) < DEPTH);
    if (iss) exp_addr.push_back(m_pc);
    @(posedge clk);
    if (rsp) begin
      fr = inflight.pop_front();
      if (!redir && !fr.stale) exp_dec.push_back('{pc: fr.pc, instr: rdata});
    end
    if (redir) begin
      exp_dec.delete();
      foreach (inflight[i]) inflight[i].stale = 1'b1;
      m_pc = rpc & 32'hFFFF_FFFC;
    end else if (iss) begin
      inflight.push_back('{pc: m_pc, stale: 1'b0});
      m_pc = m_pc + 32'd4;
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst                = 1'b1;
    bus.redirect       = 1'b0;
    bus.sub_ready      = 1'b1;
    bus.dec_pop        = 1'b0;
    bus.sub_data_valid = 1'b0;
    #1;
    chk("rst_sub_new_request", 32'(bus.sub_new_request), 32'd0);
    chk("rst_dec_valid",       32'(bus.dec_valid),       32'd0);
    chk("rst_flush_pending",   32'(bus.flush_pending),   32'd0);
    chk("rst_sub_addr",        bus.sub_addr,             RESET_PC);
    inflight.delete(); exp_dec.delete(); exp_addr.delete();
    m_pc = RESET_PC;
    @(negedge clk);
    bus.sub_ready = 1'b0;
    rst           = 1'b0;
  endtask

  // Monitor: compares whatever the DUT presents against the scoreboard queues.
  initial forever begin
    @(negedge clk);
    #2;
    if (!rst) begin
      mon_ei = (exp_addr.size() != 0);
      if (bus.sub_new_request) n_req++;
      chk("issue", 32'(bus.sub_new_request), 32'(mon_ei));
      if (mon_ei && bus.sub_new_request) chk("sub_addr", bus.sub_addr, exp_addr[0]);
      exp_addr.delete();
      chk("dec_valid", 32'(bus.dec_valid), 32'(exp_dec.size() != 0));
      if ((exp_dec.size() != 0) && bus.dec_pop && !bus.redirect) begin
        chk("dec_pc",    bus.dec_pc,    exp_dec[0].pc);
        chk("dec_instr", bus.dec_instr, exp_dec[0].instr);
        void'(exp_dec.pop_front());
      end
      chk("flush_pending", 32'(bus.flush_pending), 32'(any_stale()));
    end
  end

  initial begin
    bus.redirect = 1'b0; bus.redirect_pc = '0; bus.sub_ready = 1'b0;
    bus.sub_data_valid = 1'b0; bus.sub_data_out = '0; bus.dec_pop = 1'b0;
    set_pr(0, 0, 0, 0);
    do_reset();

    // Streaming hits with continuous decode.
    set_pr(100, 100, 100, 0);
    repeat (30) step();

    // Decode stalled: exactly DEPTH requests, then one pop frees one request.
    set_pr(0, 100, 100, 0);
    repeat (6) step();
    set_pr(100, 100, 0, 0);
    n0 = n_req;
    repeat (12) step();
    chk("fill_count", 32'(n_req - n0), 32'(DEPTH));
    set_pr(100, 0, 100, 0);
    n0 = n_req;
    step();
    chk("pop_issue_same_cycle", 32'(n_req - n0), 32'd1);

    // Redirect with two requests in flight.
    repeat (2) step();
    force_redir = 1'b1; force_pc = 32'h0000_1002;
    step();
    #1;
    chk("redir_flush_pending", 32'(bus.flush_pending), 32'd1);
    chk("redir_sub_addr", bus.sub_addr, 32'h0000_1000);
    set_pr(100, 100, 0, 0);
    repeat (6) step();
    #1;
    chk("redir_first_dec_pc", bus.dec_pc, 32'h0000_1000);

    // Redirect coinciding with the only outstanding response; lands at the top of memory.
    set_pr(0, 100, 100, 0);
    repeat (8) step();
    set_pr(100, 0, 0, 0);
    step();
    force_redir = 1'b1; force_pc = 32'hFFFF_FFFE;
    set_pr(100, 100, 0, 0);
    step();
    #1;
    chk("redir_rsp_flush_pending", 32'(bus.flush_pending), 32'd0);
    chk("redir_rsp_dec_valid", 32'(bus.dec_valid), 32'd0);
    chk("wrap_first_addr", bus.sub_addr, 32'hFFFF_FFFC);
    set_pr(100, 0, 0, 0);
    step();
    #1;
    chk("wrap_second_addr", bus.sub_addr, 32'h0000_0000);
    step();

    // Random traffic mixes.
    set_pr(70, 60, 60, 5);   repeat (400) step();
    set_pr(100, 90, 30, 3);  repeat (400) step();
    set_pr(40, 30, 90, 8);   repeat (400) step();

    // Reset in the middle of traffic, then resume from RESET_PC.
    set_pr(100, 50, 0, 0);
    repeat (5) step();
    do_reset();
    set_pr(100, 100, 100, 0);
    repeat (20) step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
